// File: rtl/video_clk_mon_pkg.sv
// Shared types, default constants and helpers for the video clock monitor.
package video_clk_mon_pkg;

    // Supervisor states
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        MEASURE   = 2'd1,
        RUN       = 2'd2
    } mon_state_e;

    // Defaults for a 100 MHz ui_clk watching 25 MHz / 50 MHz clocks
    localparam int unsigned DEF_WINDOW_CYCLES = 32'd1024;
    localparam int unsigned DEF_PIX_EXPECT    = 32'd256;
    localparam int unsigned DEF_SYS_EXPECT    = 32'd512;
    localparam int unsigned DEF_TOL           = 32'd4;
    localparam int unsigned DEF_GOOD_WINDOWS  = 32'd4;

    // True when |count - exp_cnt| <= tol
    function automatic logic in_tol(input int unsigned count,
                                    input int unsigned exp_cnt,
                                    input int unsigned tol);
        int unsigned diff;
        diff = (count >= exp_cnt) ? (count - exp_cnt) : (exp_cnt - count);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/video_clk_monitor_if.sv
// Status/control bundle between the clock monitor and its consumer.
interface video_clk_monitor_if #(
    parameter int unsigned CNT_W = 32'd11
) ();
    logic             clr_sticky;
    logic             video_rst;
    logic             clocks_ok;
    logic             meas_valid;
    logic [CNT_W-1:0] pix_count;
    logic [CNT_W-1:0] sys_count;
    logic             lock_lost;
    logic             freq_fault;
    logic [7:0]       fault_count;

    modport master (
        input  clr_sticky,
        output video_rst, clocks_ok, meas_valid, pix_count, sys_count,
               lock_lost, freq_fault, fault_count
    );

    modport slave (
        output clr_sticky,
        input  video_rst, clocks_ok, meas_valid, pix_count, sys_count,
               lock_lost, freq_fault, fault_count
    );
endinterface

// File: rtl/video_clk_monitor_clk_edge_counter.sv
// Counts rising edges of a foreign clock, seen from the ui_clk domain.
// A toggle flop in the monitored domain is resynchronised and every change
// of the synchronised toggle is one edge. total_o includes the edge (if any)
// arriving this cycle; restart_i zeroes the running count for the next cycle.
module clk_edge_counter #(
    parameter int unsigned CNT_W = 32'd11
) (
    input  logic             mon_clk_i,
    input  logic             ui_clk_i,
    input  logic             ui_rst_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] total_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             tog_q;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] total_s;
    logic             edge_s;

    // Toggle on every monitored rising edge
    always_ff @(posedge mon_clk_i or posedge ui_rst_i) begin
        if (ui_rst_i) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= ~tog_q;
        end
    end

    // Bring the toggle into ui_clk; stages 1 and 2 feed edge detection
    always_ff @(posedge ui_clk_i or posedge ui_rst_i) begin
        if (ui_rst_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], tog_q};
        end
    end

    assign edge_s = sync_q[2] ^ sync_q[1];

    // Saturating running total and restart handling
    always_comb begin
        total_s = cnt_q;
        if (edge_s && (cnt_q != CNT_MAX)) begin
            total_s = cnt_q + CNT_ONE;
        end else begin
            total_s = cnt_q;
        end
        cnt_d = restart_i ? {CNT_W{1'b0}} : total_s;
    end

    // Running count register
    always_ff @(posedge ui_clk_i or posedge ui_rst_i) begin
        if (ui_rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign total_o = total_s;

endmodule

// File: rtl/video_clk_monitor.sv
// Frequency and lock supervisor for the derived video clocks. Measures
// clk_pix and clk_sys over fixed ui_clk windows, tracks MMCM lock and owns
// the video-domain reset request.
module video_clk_monitor
    import video_clk_mon_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned PIX_EXPECT    = DEF_PIX_EXPECT,
    parameter int unsigned SYS_EXPECT    = DEF_SYS_EXPECT,
    parameter int unsigned TOL           = DEF_TOL,
    parameter int unsigned GOOD_WINDOWS  = DEF_GOOD_WINDOWS
) (
    input  logic                ui_clk,
    input  logic                ui_rst,
    input  logic                mmcm_locked,
    input  logic                clk_pix,
    input  logic                clk_sys,
    video_clk_monitor_if.master mon
);
    localparam int unsigned CNT_W  = $clog2(WINDOW_CYCLES) + 1;
    localparam int unsigned WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int unsigned GOOD_W = $clog2(GOOD_WINDOWS + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_WINDOWS - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

    logic              lock_meta_q, locked_q, locked_s;
    mon_state_e        state_q, state_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic              term_s, restart_s, meas_valid_d, meas_valid_q, win_good_s;
    logic [CNT_W-1:0]  pix_total_s, sys_total_s, pix_count_q, sys_count_q;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [7:0]        fault_cnt_q, fault_cnt_d;
    logic              lost_set_s, freq_set_s;
    logic              lock_lost_q, lock_lost_d, freq_fault_q, freq_fault_d;
    logic              video_rst_q, video_rst_d, clocks_ok_q, clocks_ok_d;

    // Two-flop synchroniser for the asynchronous MMCM lock
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            lock_meta_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            lock_meta_q <= mmcm_locked;
            locked_q    <= lock_meta_q;
        end
    end

    assign locked_s = locked_q;

    // Edge counters are held clear while waiting for lock and restart after each window
    assign restart_s = term_s || (state_q == WAIT_LOCK);

    clk_edge_counter #(.CNT_W(CNT_W)) u_pix_cnt (
        .mon_clk_i (clk_pix),
        .ui_clk_i  (ui_clk),
        .ui_rst_i  (ui_rst),
        .restart_i (restart_s),
        .total_o   (pix_total_s)
    );

    clk_edge_counter #(.CNT_W(CNT_W)) u_sys_cnt (
        .mon_clk_i (clk_sys),
        .ui_clk_i  (ui_clk),
        .ui_rst_i  (ui_rst),
        .restart_i (restart_s),
        .total_o   (sys_total_s)
    );

    // Window counter, terminal-cycle detect and result qualification
    always_comb begin
        win_cnt_d    = (state_q == WAIT_LOCK) ? {WIN_W{1'b0}} : (win_cnt_q + WIN_ONE);
        term_s       = (state_q != WAIT_LOCK) && (win_cnt_q == WIN_LAST);
        // A window closing while lock is lost is discarded
        meas_valid_d = term_s && locked_s;
        win_good_s   = in_tol(32'(pix_count_q), PIX_EXPECT, TOL) &&
                       in_tol(32'(sys_count_q), SYS_EXPECT, TOL);
    end

    // Window counter and latched measurement registers
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            win_cnt_q    <= {WIN_W{1'b0}};
            pix_count_q  <= {CNT_W{1'b0}};
            sys_count_q  <= {CNT_W{1'b0}};
            meas_valid_q <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            meas_valid_q <= meas_valid_d;
            if (meas_valid_d) begin
                pix_count_q <= pix_total_s;
                sys_count_q <= sys_total_s;
            end
        end
    end

    // State register with window bookkeeping and sticky flags
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            state_q      <= WAIT_LOCK;
            good_cnt_q   <= {GOOD_W{1'b0}};
            fault_cnt_q  <= 8'd0;
            lock_lost_q  <= 1'b0;
            freq_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            fault_cnt_q  <= fault_cnt_d;
            lock_lost_q  <= lock_lost_d;
            freq_fault_q <= freq_fault_d;
        end
    end

    // Next state: lock loss dominates any window result evaluated this cycle
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        fault_cnt_d = fault_cnt_q;
        lost_set_s  = 1'b0;
        freq_set_s  = 1'b0;
        if (!locked_s) begin
            state_d    = WAIT_LOCK;
            good_cnt_d = {GOOD_W{1'b0}};
            lost_set_s = (state_q != WAIT_LOCK);
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d    = MEASURE;
                    good_cnt_d = {GOOD_W{1'b0}};
                end
                MEASURE: begin
                    if (meas_valid_q && win_good_s) begin
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d    = RUN;
                            good_cnt_d = {GOOD_W{1'b0}};
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_ONE;
                        end
                    end else if (meas_valid_q) begin
                        good_cnt_d  = {GOOD_W{1'b0}};
                        fault_cnt_d = (fault_cnt_q == 8'hFF) ? 8'hFF : (fault_cnt_q + 8'd1);
                    end else begin
                        good_cnt_d = good_cnt_q;
                    end
                end
                RUN: begin
                    if (meas_valid_q && !win_good_s) begin
                        state_d     = MEASURE;
                        good_cnt_d  = {GOOD_W{1'b0}};
                        freq_set_s  = 1'b1;
                        fault_cnt_d = (fault_cnt_q == 8'hFF) ? 8'hFF : (fault_cnt_q + 8'd1);
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d    = WAIT_LOCK;
                    good_cnt_d = {GOOD_W{1'b0}};
                end
            endcase
        end
        // A new event on the same cycle wins over clr_sticky
        lock_lost_d  = lost_set_s ? 1'b1 : (mon.clr_sticky ? 1'b0 : lock_lost_q);
        freq_fault_d = freq_set_s ? 1'b1 : (mon.clr_sticky ? 1'b0 : freq_fault_q);
    end

    // Outputs decoded from the next state so they change with the state register
    always_comb begin
        video_rst_d = (state_d != RUN);
        clocks_ok_d = (state_d == RUN);
    end

    // Registered video reset and clocks-ok outputs
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            video_rst_q <= 1'b1;
            clocks_ok_q <= 1'b0;
        end else begin
            video_rst_q <= video_rst_d;
            clocks_ok_q <= clocks_ok_d;
        end
    end

    assign mon.video_rst   = video_rst_q;
    assign mon.clocks_ok   = clocks_ok_q;
    assign mon.meas_valid  = meas_valid_q;
    assign mon.pix_count   = pix_count_q;
    assign mon.sys_count   = sys_count_q;
    assign mon.lock_lost   = lock_lost_q;
    assign mon.freq_fault  = freq_fault_q;
    assign mon.fault_count = fault_cnt_q;

endmodule

// File: tb/tb_video_clk_monitor.sv
// Directed bench for video_clk_monitor using a shortened 128-cycle window
// (pix expect 32, sys expect 64, tolerance 4, 4 good windows).
module tb_video_clk_monitor;
    localparam int CNT_W = 8;

    logic ui_clk      = 1'b0;
    logic clk_pix     = 1'b0;
    logic clk_sys     = 1'b0;
    logic ui_rst      = 1'b1;
    logic mmcm_locked = 1'b0;
    int   pix_half    = 20;
    bit   sys_en      = 1'b1;

    int checks     = 0;
    int errors     = 0;
    int mv_cnt     = 0;
    int ok_cycles  = 0;
    bit nominal    = 1'b0;
    int mv_snap;
    int ok_snap;

    video_clk_monitor_if #(.CNT_W(CNT_W)) mon ();

    video_clk_monitor #(
        .WINDOW_CYCLES (128),
        .PIX_EXPECT    (32),
        .SYS_EXPECT    (64),
        .TOL           (4),
        .GOOD_WINDOWS  (4)
    ) dut (
        .ui_clk      (ui_clk),
        .ui_rst      (ui_rst),
        .mmcm_locked (mmcm_locked),
        .clk_pix     (clk_pix),
        .clk_sys     (clk_sys),
        .mon         (mon)
    );

    always #5 ui_clk = ~ui_clk;
    always begin #(pix_half); clk_pix = ~clk_pix; end
    always begin #10; if (sys_en) clk_sys = ~clk_sys; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Count measurement pulses / RUN cycles; check counts while clocks are nominal
    always @(negedge ui_clk) begin
        if (mon.meas_valid === 1'b1) begin
            mv_cnt++;
            if (nominal) begin
                chk("nom_pix_range", (mon.pix_count >= 8'd31 && mon.pix_count <= 8'd33), 1);
                chk("nom_sys_range", (mon.sys_count >= 8'd63 && mon.sys_count <= 8'd65), 1);
            end
        end
        if (mon.clocks_ok === 1'b1) ok_cycles++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ui_clk);
    endtask

    task automatic wait_mv(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge ui_clk);
            k++;
        end while (mon.meas_valid !== 1'b1 && k < 400);
        if (mon.meas_valid !== 1'b1) chk({tag, "_mv_timeout"}, 0, 1);
    endtask

    task automatic wait_release(input string tag, input int lo, input int hi);
        int n;
        n = 0;
        while (mon.video_rst !== 1'b0 && n < hi + 50) begin
            @(negedge ui_clk);
            n++;
        end
        chk($sformatf("%s_cycles_%0d", tag, n), (n >= lo && n <= hi), 1);
    endtask

    initial begin
        mon.clr_sticky = 1'b0;
        cyc(3);
        chk("rst_video_rst", mon.video_rst, 1);
        chk("rst_clocks_ok", mon.clocks_ok, 0);
        chk("rst_meas_valid", mon.meas_valid, 0);
        chk("rst_pix_count", mon.pix_count, 0);
        chk("rst_sys_count", mon.sys_count, 0);
        chk("rst_lock_lost", mon.lock_lost, 0);
        chk("rst_freq_fault", mon.freq_fault, 0);
        chk("rst_fault_count", mon.fault_count, 0);
        ui_rst = 1'b0;

        // 1: lock and release after four good windows (~516 cycles)
        cyc(50);
        mmcm_locked = 1'b1;
        nominal = 1'b1;
        wait_release("t1_release", 510, 525);
        chk("t1_clocks_ok", mon.clocks_ok, 1);
        chk("t1_mv_cnt", mv_cnt, 4);
        chk("t1_fault_count", mon.fault_count, 0);
        chk("t1_lock_lost", mon.lock_lost, 0);

        // 2: lock loss in RUN, then relock
        cyc(200);
        mmcm_locked = 1'b0;
        cyc(4);
        chk("t2_video_rst", mon.video_rst, 1);
        chk("t2_clocks_ok", mon.clocks_ok, 0);
        chk("t2_lock_lost", mon.lock_lost, 1);
        mv_snap = mv_cnt;
        cyc(300);
        chk("t2_no_meas_valid", mv_cnt - mv_snap, 0);
        mmcm_locked = 1'b1;
        wait_release("t2_relock", 510, 525);
        chk("t2_lock_lost_sticky", mon.lock_lost, 1);
        mon.clr_sticky = 1'b1;
        cyc(1);
        mon.clr_sticky = 1'b0;
        chk("t2_lock_lost_clr", mon.lock_lost, 0);
        chk("t2_freq_fault", mon.freq_fault, 0);

        // 3: clk_sys stopped for three windows
        wait_mv("t3_sync");
        nominal = 1'b0;
        sys_en = 1'b0;
        for (int i = 0; i < 3; i++) wait_mv("t3_bad");
        chk("t3_sys_zero", mon.sys_count, 0);
        sys_en = 1'b1;
        cyc(1);
        chk("t3_fault_count", mon.fault_count, 3);
        chk("t3_freq_fault", mon.freq_fault, 1);
        chk("t3_video_rst", mon.video_rst, 1);
        chk("t3_clocks_ok", mon.clocks_ok, 0);
        wait_release("t3_release", 1, 6 * 128);
        chk("t3_freq_fault_kept", mon.freq_fault, 1);
        chk("t3_fault_kept", mon.fault_count, 3);

        // 5: clear alone, then clear coinciding with a bad window in RUN
        mon.clr_sticky = 1'b1;
        cyc(1);
        mon.clr_sticky = 1'b0;
        chk("t5_clr_alone", mon.freq_fault, 0);
        wait_mv("t5_sync");
        sys_en = 1'b0;
        wait_mv("t5_bad");
        mon.clr_sticky = 1'b1;
        sys_en = 1'b1;
        pix_half = 16;
        cyc(1);
        mon.clr_sticky = 1'b0;
        chk("t5_set_wins", mon.freq_fault, 1);
        chk("t5_fault_count", mon.fault_count, 4);
        chk("t5_video_rst", mon.video_rst, 1);

        // 4: clk_pix too fast (~40 edges): never RUN, fault_count saturates
        ok_snap = ok_cycles;
        for (int i = 0; i < 5; i++) wait_mv("t4_a");
        cyc(1);
        chk("t4_fault_9", mon.fault_count, 9);
        for (int i = 0; i < 255; i++) wait_mv("t4_b");
        chk("t4_pix_fast", (mon.pix_count >= 8'd38 && mon.pix_count <= 8'd42), 1);
        cyc(1);
        chk("t4_fault_sat", mon.fault_count, 255);
        chk("t4_never_run", ok_cycles - ok_snap, 0);

        // 6: reset mid-window in RUN, then full sequence again
        pix_half = 20;
        wait_release("t6_pre", 1, 7 * 128);
        cyc(50);
        #2;
        ui_rst = 1'b1;
        #1;
        chk("t6_video_rst", mon.video_rst, 1);
        chk("t6_clocks_ok", mon.clocks_ok, 0);
        chk("t6_fault_count", mon.fault_count, 0);
        chk("t6_freq_fault", mon.freq_fault, 0);
        chk("t6_pix_count", mon.pix_count, 0);
        chk("t6_sys_count", mon.sys_count, 0);
        cyc(3);
        ui_rst = 1'b0;
        nominal = 1'b1;
        wait_release("t6_release", 510, 525);
        chk("t6_fault_after", mon.fault_count, 0);
        chk("t6_clocks_ok_after", mon.clocks_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_clk_monitor.md
Name: video_clk_monitor

Overview:
Frequency and lock supervisor for the derived video clocks (25 MHz pixel, 50 MHz system). The block sits in the ui_clk domain and measures both derived clocks against ui_clk over fixed windows. It also tracks the MMCM lock signal. It owns the video-domain reset request and releases it only after several consecutive in-tolerance windows; it re-asserts it on lock loss or frequency fault.

Parameters:
WINDOW_CYCLES, 1024, ui_clk cycles per measurement window (power of two, >=64)
PIX_EXPECT, 256, expected clk_pix rising edges per window (25/100 * WINDOW_CYCLES)
SYS_EXPECT, 512, expected clk_sys rising edges per window
TOL, 4, allowed absolute deviation from expected count (inclusive)
GOOD_WINDOWS, 4, consecutive good windows required before release
CNT_W, $clog2(WINDOW_CYCLES)+1, measured-count width (derived)

Ports:
ui_clk  in  1  monitoring/reference clock (~100 MHz)
ui_rst  in  1  reset, asynchronous, active-high
mmcm_locked  in  1  MMCM lock, asynchronous to ui_clk
clk_pix  in  1  monitored 25 MHz clock
clk_sys  in  1  monitored 50 MHz clock
clr_sticky  in  1  ui_clk pulse, clears lock_lost/freq_fault
video_rst  out  1  reset request to video domains, active-high
clocks_ok  out  1  high only in RUN state
meas_valid  out  1  one-cycle pulse when pix_count/sys_count update
pix_count  out  CNT_W  last window's clk_pix edge count
sys_count  out  CNT_W  last window's clk_sys edge count
lock_lost  out  1  sticky: lock dropped while in MEASURE or RUN
freq_fault  out  1  sticky: out-of-tolerance window while in RUN
fault_count  out  8  saturating count of out-of-tolerance windows

Behaviour:
- Reset (ui_rst asserted, async): video_rst=1, clocks_ok=0, meas_valid=0, counts=0, lock_lost=0, freq_fault=0, fault_count=0, state=WAIT_LOCK. Monitored-domain toggle flops are also async-cleared by ui_rst.
- mmcm_locked passes through a 2-FF synchronizer into locked_s.
- Edge capture per monitored clock:
  - A toggle flop flips on every rising edge of the monitored clock.
  - It passes through a 3-FF synchronizer in ui_clk.
  - Each change of the synchronized toggle counts as one monitored edge.
  - The edge counter saturates at all-ones.
- Window counter:
  - Runs 0..WINDOW_CYCLES-1 in MEASURE and RUN; held at 0 in WAIT_LOCK.
  - On the terminal cycle, edge counts (including any edge on that cycle) latch into pix_count/sys_count, and meas_valid pulses on the following cycle.
  - Edge counters restart from 0 (or 1 if an edge coincides) on the cycle after terminal.
- In-range check: |count - EXPECT| <= TOL for both clocks. The check is evaluated on the meas_valid cycle.
- FSM:
  - WAIT_LOCK: video_rst=1. When locked_s=1, go to MEASURE with good_cnt=0 and edge counters cleared.
  - MEASURE: video_rst=1.
    - Good window: good_cnt++; when it reaches GOOD_WINDOWS, go to RUN.
    - Bad window: good_cnt=0; fault_count++ (saturating at 255).
  - RUN: video_rst=0, clocks_ok=1. Windows continue to be measured.
    - Bad window: go to MEASURE, good_cnt=0, freq_fault=1, fault_count++. video_rst rises on the same cycle as the transition.
- Any state with locked_s=0: next state is WAIT_LOCK; lock_lost=1 if the current state was MEASURE or RUN.
  - Lock loss overrides a simultaneous window result: no good_cnt or fault_count update, and meas_valid is suppressed.
- Sticky flags: clr_sticky clears lock_lost and freq_fault. A set on the same cycle wins over clear. fault_count is cleared only by ui_rst.
- video_rst and clocks_ok are registered outputs with no combinational path from inputs.
- Synchronizer latency may skew a window's count by ±1; TOL must be >=2.

Decomposition:
- Package video_clk_mon_pkg: state enum (WAIT_LOCK, MEASURE, RUN), default expected-count constants, helper function in_tol(count, expect, tol).
- Sub-module clk_edge_counter, instantiated twice: toggle flop, 3-FF synchronizer, edge detect, saturating counter with clear/latch controls.
- Top level holds the window counter, FSM, stickies and outputs.

Test Plan:
1. Reset release, mmcm_locked=1 at 50 cycles, clk_pix 25 MHz, clk_sys 50 MHz -> pix_count in 255..257, sys_count in 511..513 each window. video_rst falls after the 4th good window (~4100 ui_clk cycles after lock); clocks_ok=1; fault_count=0.
2. In RUN, drop mmcm_locked -> video_rst=1 and clocks_ok=0 within 4 ui_clk cycles; lock_lost=1; no further meas_valid. Relock -> release again after 4 windows.
3. In RUN, stop clk_sys for 3 windows -> sys_count=0, freq_fault=1, fault_count=3, video_rst=1. Restart -> release after 4 good windows; freq_fault stays 1.
4. clk_pix at 27 MHz (count ~276) -> never reaches RUN; fault_count increments per window and saturates at 255.
5. clr_sticky on the same cycle as a new bad window in RUN -> freq_fault remains 1. clr_sticky alone later -> freq_fault=0 next cycle.
6. ui_rst pulse mid-window in RUN -> all outputs at reset values immediately. After release, full WAIT_LOCK->MEASURE->RUN sequence repeats with fault_count=0.
